stage_decode_fwd: RTL

- Parametrised successor decode stage for the 5-stage RV32I pipeline; sits between fetch and execute.
- Decodes the instruction, reads the register file and builds the full immediate set (I/S/B/U/J).
- Adds EX/MEM/WB operand forwarding (FWD_EN=1) or stall-only interlock (FWD_EN=0), load-use stall, valid/ready handshake on both sides, and a branch flush.

---
 rtl/stage_decode_fwd_pkg.sv | 74 +++++++
 rtl/register_file.sv | 43 ++++
 rtl/stage_decode_fwd_hazard_fwd_unit.sv | 67 ++++++
 rtl/stage_decode_fwd.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/stage_decode_fwd_pkg.sv
// rtl/stage_decode_fwd_pkg.sv - opcodes, decode types and decode helpers for the decode stage
package stage_decode_fwd_pkg;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    typedef enum logic [1:0] {FWD_RF, FWD_WB, FWD_MEM, FWD_EX} fwd_sel_e;

    typedef struct packed {
        logic op;
        logic ld;
        logic st;
        logic jm;
        logic br;
        logic ui;
        logic reg_write;
    } decode_ctrl_t;

    // op covers both register and immediate ALU forms; reg_write is not yet masked by rd != 0
    function automatic decode_ctrl_t decode_class(input logic [6:0] opc);
        decode_ctrl_t c;
        c = '0;
        case (opc)
            OPCODE_OP, OPCODE_OPIMM:  c.op = 1'b1;
            OPCODE_LOAD:              c.ld = 1'b1;
            OPCODE_STORE:             c.st = 1'b1;
            OPCODE_JAL, OPCODE_JALR:  c.jm = 1'b1;
            OPCODE_BRANCH:            c.br = 1'b1;
            OPCODE_LUI, OPCODE_AUIPC: c.ui = 1'b1;
            default:                  c = '0;
        endcase
        c.reg_write = c.op | c.ld | c.jm | c.ui;
        return c;
    endfunction

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
        case (opc)
            OPCODE_STORE:             return IMM_S;
            OPCODE_BRANCH:            return IMM_B;
            OPCODE_LUI, OPCODE_AUIPC: return IMM_U;
            OPCODE_JAL:               return IMM_J;
            default:                  return IMM_I;
        endcase
    endfunction

    // returns {uses_rs2, uses_rs1}
    function automatic logic [1:0] src_use(input logic [6:0] opc);
        case (opc)
            OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH:   return 2'b11;
            OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR:   return 2'b01;
            default:                                  return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] build_imm(input logic [31:0] ins, input imm_fmt_e fmt);
        case (fmt)
            IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   return {ins[31:12], 12'b0};
            IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return {{20{ins[31]}}, ins[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - two-read one-write register file with x0 tied to zero and write-through reads
module register_file import stage_decode_fwd_pkg::*; #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic [AW-1:0]   ra1_i,
    input  logic [AW-1:0]   ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // next contents: single write port, x0 never written
    always_comb begin
        regs_d = regs_q;
        if (we_i && wa_i != '0) begin
            regs_d[wa_i] = wd_i;
        end
    end

    // storage update with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : ((we_i && wa_i == ra1_i) ? wd_i : regs_q[ra1_i]);
    assign rd2_o = (ra2_i == '0) ? '0 : ((we_i && wa_i == ra2_i) ? wd_i : regs_q[ra2_i]);

endmodule

// File: rtl/stage_decode_fwd_hazard_fwd_unit.sv
// rtl/stage_decode_fwd_hazard_fwd_unit.sv - combinational hazard detection and operand forward selection
module hazard_fwd_unit import stage_decode_fwd_pkg::*; #(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              valid_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic              use_rs1_i,
    input  logic              use_rs2_i,
    input  logic              ex_we_i,
    input  logic              ex_ld_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              mem_we_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    output logic              hazard_o,
    output fwd_sel_e          fwd1_o,
    output fwd_sel_e          fwd2_o
);

    logic [REG_AW-1:0] rs   [2];
    logic              used [2];
    fwd_sel_e          sel  [2];
    logic              hz;
    logic              nz;
    logic              ex_hit;
    logic              mem_hit;
    logic              wb_hit;

    // per source: stall on a producer that cannot be forwarded, else pick the youngest producer
    always_comb begin
        rs[0]    = rs1_i;
        rs[1]    = rs2_i;
        used[0]  = use_rs1_i;
        used[1]  = use_rs2_i;
        sel[0]   = FWD_RF;
        sel[1]   = FWD_RF;
        hazard_o = 1'b0;
        hz       = 1'b0;
        nz       = 1'b0;
        ex_hit   = 1'b0;
        mem_hit  = 1'b0;
        wb_hit   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nz      = (rs[i] != '0);
            ex_hit  = nz & ex_we_i & (rs[i] == ex_rd_i);
            mem_hit = nz & mem_we_i & (rs[i] == mem_rd_i);
            wb_hit  = nz & wb_we_i & (rs[i] == wb_rd_i);
            if (FWD_EN) begin
                hz = used[i] & ex_hit & ex_ld_i;
                if (ex_hit && !ex_ld_i) sel[i] = FWD_EX;
                else if (mem_hit)       sel[i] = FWD_MEM;
                else if (wb_hit)        sel[i] = FWD_WB;
            end else begin
                hz = used[i] & (ex_hit | mem_hit);
                if (wb_hit)             sel[i] = FWD_WB;
            end
            hazard_o = hazard_o | (valid_i & hz);
        end
    end

    assign fwd1_o = sel[0];
    assign fwd2_o = sel[1];

endmodule

// File: rtl/stage_decode_fwd.sv
// rtl/stage_decode_fwd.sv - RV32I decode stage with forwarding or interlock, handshake and flush
module stage_decode_fwd import stage_decode_fwd_pkg::*; #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int REG_AW = $clog2(NREGS),
    parameter int PC_W   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [31:0]       instr_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    input  logic              ex_we_i,
    input  logic              ex_ld_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [XLEN-1:0]   ex_data_i,
    input  logic              mem_we_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic [XLEN-1:0]   mem_data_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [6:0]        opcode_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic [XLEN-1:0]   imm_o,
    output logic              ctrl_op_o,
    output logic              ctrl_ld_o,
    output logic              ctrl_st_o,
    output logic              ctrl_jm_o,
    output logic              ctrl_br_o,
    output logic              ctrl_ui_o,
    output logic              reg_write_o,
    output logic              stall_o
);

    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [1:0]        use_src;
    decode_ctrl_t      ctrl_dec;
    logic [XLEN-1:0]   rf_rd1, rf_rd2, op1, op2;
    fwd_sel_e          fwd1, fwd2;
    logic              hazard, adv;

    logic              valid_q, valid_d, stall_q, stall_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [6:0]        opcode_q, opcode_d, funct7_q, funct7_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
    decode_ctrl_t      ctrl_q, ctrl_d;

    assign rs1     = REG_AW'(instr_i[19:15]);
    assign rs2     = REG_AW'(instr_i[24:20]);
    assign rd      = REG_AW'(instr_i[11:7]);
    assign use_src = src_use(instr_i[6:0]);

    register_file #(.NREGS(NREGS), .XLEN(XLEN), .AW(REG_AW)) u_rf (
        .clk   (clk),
        .reset (reset),
        .we_i  (wb_we_i),
        .wa_i  (wb_rd_i),
        .wd_i  (wb_data_i),
        .ra1_i (rs1),
        .ra2_i (rs2),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2)
    );

    hazard_fwd_unit #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_hazard (
        .valid_i   (valid_i),
        .rs1_i     (rs1),
        .rs2_i     (rs2),
        .use_rs1_i (use_src[0]),
        .use_rs2_i (use_src[1]),
        .ex_we_i   (ex_we_i),
        .ex_ld_i   (ex_ld_i),
        .ex_rd_i   (ex_rd_i),
        .mem_we_i  (mem_we_i),
        .mem_rd_i  (mem_rd_i),
        .wb_we_i   (wb_we_i),
        .wb_rd_i   (wb_rd_i),
        .hazard_o  (hazard),
        .fwd1_o    (fwd1),
        .fwd2_o    (fwd2)
    );

    // operand selection and control decode of the incoming word
    always_comb begin
        case (fwd1)
            FWD_EX:  op1 = ex_data_i;
            FWD_MEM: op1 = mem_data_i;
            FWD_WB:  op1 = wb_data_i;
            default: op1 = rf_rd1;
        endcase
        case (fwd2)
            FWD_EX:  op2 = ex_data_i;
            FWD_MEM: op2 = mem_data_i;
            FWD_WB:  op2 = wb_data_i;
            default: op2 = rf_rd2;
        endcase
        ctrl_dec           = decode_class(instr_i[6:0]);
        ctrl_dec.reg_write = ctrl_dec.reg_write & (rd != '0);
    end

    assign adv     = ready_i | !valid_q;
    assign ready_o = flush_i | (adv & !hazard);

    // output register: flush kills, hazard inserts a bubble, otherwise load or hold
    always_comb begin
        valid_d  = valid_q;
        stall_d  = stall_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        funct3_d = funct3_q;
        funct7_d = funct7_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        ctrl_d   = ctrl_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            stall_d = 1'b0;
        end else if (adv) begin
            if (hazard) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                stall_d = 1'b1;
            end else if (valid_i) begin
                valid_d  = 1'b1;
                stall_d  = 1'b0;
                pc_d     = pc_i;
                opcode_d = instr_i[6:0];
                funct3_d = instr_i[14:12];
                funct7_d = instr_i[31:25];
                rd_d     = rd;
                rs1_d    = op1;
                rs2_d    = op2;
                imm_d    = XLEN'($signed(build_imm(instr_i, imm_fmt(instr_i[6:0]))));
                ctrl_d   = ctrl_dec;
            end else begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                stall_d = 1'b0;
            end
        end
    end

    // state registers with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            stall_q  <= 1'b0;
            pc_q     <= '0;
            opcode_q <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            ctrl_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            stall_q  <= stall_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            funct3_q <= funct3_d;
            funct7_q <= funct7_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign valid_o     = valid_q;
    assign stall_o     = stall_q;
    assign pc_o        = pc_q;
    assign opcode_o    = opcode_q;
    assign funct3_o    = funct3_q;
    assign funct7_o    = funct7_q;
    assign rd_o        = rd_q;
    assign rs1_data_o  = rs1_q;
    assign rs2_data_o  = rs2_q;
    assign imm_o       = imm_q;
    assign ctrl_op_o   = ctrl_q.op;
    assign ctrl_ld_o   = ctrl_q.ld;
    assign ctrl_st_o   = ctrl_q.st;
    assign ctrl_jm_o   = ctrl_q.jm;
    assign ctrl_br_o   = ctrl_q.br;
    assign ctrl_ui_o   = ctrl_q.ui;
    assign reg_write_o = ctrl_q.reg_write;

endmodule
